sb_timer_responder: RTL

Soft responder on the 8-bit system bus that sits alongside the SB_SPI hard IP, on the far side of the `wishbone` master. It decodes one 16-byte address window, completes read/write cycles with the same strobe/ack handshake the hard IPs use, and hosts a prescaled 16-bit down-counter timer with an interrupt. Its `irq` output feeds the system bus wrapper's interrupt line, which is currently tied low.

---
 rtl/sb_pkg.sv | 24 ++
 rtl/sb_timer_core.sv | 54 +++++
 rtl/sb_timer_responder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sb_pkg.sv
// Shared types and constants for the system-bus timer responder.
package sb_pkg;
    localparam int SB_ADDR_W = 8;
    localparam int SB_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_HOLD
    } bus_state_t;

    localparam logic [3:0] REG_CTRL      = 4'h0;
    localparam logic [3:0] REG_STAT      = 4'h1;
    localparam logic [3:0] REG_RELOAD_LO = 4'h2;
    localparam logic [3:0] REG_RELOAD_HI = 4'h3;
    localparam logic [3:0] REG_COUNT_LO  = 4'h4;
    localparam logic [3:0] REG_COUNT_HI  = 4'h5;
    localparam logic [3:0] REG_PRESCALE  = 4'h6;

    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_IRQEN      = 2;
endpackage

// File: rtl/sb_timer_core.sv
// Prescaled 16-bit down-counter; flags expiry and asks the top to drop EN in one-shot mode.
module sb_timer_core
    import sb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        autoreload,
    input  logic [15:0] reload,
    input  logic [7:0]  prescale,
    input  logic        load,
    output logic [15:0] count,
    output logic        expire,
    output logic        en_clr
);
    logic [7:0]  pre_q, pre_d;
    logic [15:0] count_q, count_d;
    logic        tick;

    always_comb begin
        pre_d   = pre_q;
        count_d = count_q;
        expire  = 1'b0;
        en_clr  = 1'b0;
        tick    = en && (pre_q == prescale);
        if (load) begin
            pre_d   = 8'd0;
            count_d = reload;
        end else if (en) begin
            pre_d = tick ? 8'd0 : pre_q + 8'd1;
            if (tick) begin
                if (count_q != 16'd0) begin
                    count_d = count_q - 16'd1;
                end else begin
                    expire = 1'b1;
                    if (autoreload) count_d = reload;
                    else            en_clr  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= 8'd0;
            count_q <= 16'd0;
        end else begin
            pre_q   <= pre_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/sb_timer_responder.sv
// Bus responder for one 16-byte window: handshake FSM, timer registers, read mux and irq.
//   state   | meaning
//   IDLE    | waiting for a strobe to this window
//   WAIT    | inserting WAIT_STATES cycles before ack
//   ACK     | one-cycle ack, writes commit here
//   HOLD    | ack given, waiting for the strobe to drop
module sb_timer_responder
    import sb_pkg::*;
#(
    parameter logic [3:0]  BUS_ADDR74  = 4'b0001,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sbstbi,
    input  logic                 sbrwi,
    input  logic [SB_ADDR_W-1:0] sbadri,
    input  logic [SB_DATA_W-1:0] sbdati,
    output logic [SB_DATA_W-1:0] sbdato,
    output logic                 sbacko,
    output logic                 irq
);
    localparam logic [2:0] WAIT_LOAD = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    bus_state_t     state_q, state_d;
    logic [2:0]     wait_q, wait_d;
    logic [2:0]     ctrl_q, ctrl_d;
    logic           exp_q, exp_d;
    logic [15:0]    reload_q, reload_d;
    logic [7:0]     presc_q, presc_d;
    logic [7:0]     shadow_q, shadow_d;
    logic [7:0]     dato_q, dato_d;
    logic [7:0]     rd_mux;
    logic [15:0]    count;
    logic [3:0]     off;
    logic           sel, go_ack, wr, rd_capture, load, expire, en_clr;

    assign off = sbadri[3:0];
    assign sel = sbstbi && (sbadri[7:4] == BUS_ADDR74);
    assign go_ack = ((state_q == ST_IDLE) && sel && (WAIT_STATES == 0)) ||
                    ((state_q == ST_WAIT) && (wait_q == 3'd0));
    assign wr = (state_q == ST_ACK) && sbrwi;
    assign rd_capture = go_ack && !sbrwi;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wait_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_IDLE: if (sel) begin
                state_d = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
                wait_d  = WAIT_LOAD;
            end
            ST_WAIT: if (wait_q == 3'd0) state_d = ST_ACK;
                     else                wait_d  = wait_q - 3'd1;
            ST_ACK:  state_d = ST_HOLD;
            ST_HOLD: if (!sbstbi) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sbacko = (state_q == ST_ACK);
        sbdato = dato_q;
    end

    always_comb begin
        case (off)
            REG_CTRL:      rd_mux = {5'd0, ctrl_q};
            REG_STAT:      rd_mux = {7'd0, exp_q};
            REG_RELOAD_LO: rd_mux = reload_q[7:0];
            REG_RELOAD_HI: rd_mux = reload_q[15:8];
            REG_COUNT_LO:  rd_mux = count[7:0];
            REG_COUNT_HI:  rd_mux = shadow_q;
            REG_PRESCALE:  rd_mux = presc_q;
            default:       rd_mux = 8'h00;
        endcase
    end

    // Expiry set is applied last so it beats a same-cycle write-1-clear.
    always_comb begin
        ctrl_d   = ctrl_q;
        exp_d    = exp_q;
        reload_d = reload_q;
        presc_d  = presc_q;
        load     = 1'b0;
        dato_d   = rd_capture ? rd_mux : 8'h00;
        shadow_d = (rd_capture && off == REG_COUNT_LO) ? count[15:8] : shadow_q;
        if (en_clr) ctrl_d[CTRL_EN] = 1'b0;
        if (wr) begin
            case (off)
                REG_CTRL: begin
                    ctrl_d = sbdati[2:0];
                    load   = sbdati[CTRL_EN] && !ctrl_q[CTRL_EN];
                end
                REG_STAT:      if (sbdati[0]) exp_d = 1'b0;
                REG_RELOAD_LO: reload_d[7:0]  = sbdati;
                REG_RELOAD_HI: reload_d[15:8] = sbdati;
                REG_PRESCALE:  presc_d = sbdati;
                default: ;
            endcase
        end
        if (expire) exp_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q   <= 3'd0;
            exp_q    <= 1'b0;
            reload_q <= 16'd0;
            presc_q  <= 8'd0;
            shadow_q <= 8'd0;
            dato_q   <= 8'd0;
        end else begin
            ctrl_q   <= ctrl_d;
            exp_q    <= exp_d;
            reload_q <= reload_d;
            presc_q  <= presc_d;
            shadow_q <= shadow_d;
            dato_q   <= dato_d;
        end
    end

    sb_timer_core u_core (
        .clk        (clk),
        .rst        (rst),
        .en         (ctrl_q[CTRL_EN]),
        .autoreload (ctrl_q[CTRL_AUTORELOAD]),
        .reload     (reload_q),
        .prescale   (presc_q),
        .load       (load),
        .count      (count),
        .expire     (expire),
        .en_clr     (en_clr)
    );

    assign irq = exp_q && ctrl_q[CTRL_IRQEN];
endmodule
